mod_instruction_fetch_unit: RTL and testbench

MOD_INSTRUCTION_FETCH_UNIT -- requirements
Module: mod_instruction_fetch_unit

---
 rtl/mod_instruction_fetch_unit.sv | 176 +++++++++++++++++
 tb/tb_mod_instruction_fetch_unit.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_instruction_fetch_unit.sv
// Instruction fetch unit: loads a program into local storage, then streams it out
// under valid/ready flow control with branch redirect. Define FETCH_COUNT_EN to add fetch_count.
module mod_instruction_fetch_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 30,
    parameter int DEPTH      = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    input  logic                  fetch_en,
    input  logic                  redirect_en,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  mem_end
`ifdef FETCH_COUNT_EN
    ,
    output logic [31:0]           fetch_count
`endif
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so prog_len can hold DEPTH and load_addr+1 never wraps.
    localparam int LEN_W = ADDR_WIDTH + 1;
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rp_q, rp_d;
    logic [LEN_W-1:0]      prog_len_q, prog_len_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] instruction_q, instruction_d;
    logic [ADDR_WIDTH-1:0] address_q, address_d;
    logic                  mem_end_q, mem_end_d;
`ifdef FETCH_COUNT_EN
    logic [31:0]           fetch_count_q, fetch_count_d;
`endif

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  load_in_range;
    logic                  mem_we;
    logic [LEN_W-1:0]      load_len;
    logic [LEN_W-1:0]      load_len_clip;
    logic                  rp_in_range;
    logic                  rp_in_prog;
    logic                  slot_free;
    logic [DATA_WIDTH-1:0] rd_data;

    assign load_in_range = {1'b0, load_addr} < DEPTH_L;
    assign mem_we        = (state_q == IDLE) && load_en && load_in_range;
    assign load_len      = {1'b0, load_addr} + LEN_W'(1);
    assign load_len_clip = (load_len > DEPTH_L) ? DEPTH_L : load_len;
    assign rp_in_range   = {1'b0, rp_q} < DEPTH_L;
    assign rp_in_prog    = {1'b0, rp_q} < prog_len_q;
    assign rd_data       = rp_in_range ? mem[rp_q[IDX_W-1:0]] : '0;
    assign slot_free     = !out_valid_q || out_ready;

    // NOTE: the program store has no reset so it maps onto plain RAM and survives rst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[load_addr[IDX_W-1:0]] <= load_data;
        end
    end

    // NOTE: every *_d gets a hold value first so no path through the case infers a latch.
    always_comb begin
        state_d       = state_q;
        rp_d          = rp_q;
        prog_len_d    = prog_len_q;
        out_valid_d   = out_valid_q;
        instruction_d = instruction_q;
        address_d     = address_q;

        case (state_q)
            IDLE: begin
                out_valid_d = 1'b0;
                if (load_en && load_last) begin
                    prog_len_d = load_len_clip;
                end
                // A load_last beat in the same cycle already counts toward the length.
                if (fetch_en && (prog_len_d != '0)) begin
                    state_d = RUN;
                    rp_d    = '0;
                end
            end
            RUN: begin
                if (redirect_en) begin
                    out_valid_d = 1'b0;
                    rp_d        = redirect_addr;
                end else if (slot_free) begin
                    if (!rp_in_prog) begin
                        out_valid_d = 1'b0;
                        state_d     = DONE;
                    end else if (fetch_en) begin
                        instruction_d = rd_data;
                        address_d     = rp_q;
                        out_valid_d   = 1'b1;
                        rp_d          = rp_q + ADDR_WIDTH'(1);
                    end else begin
                        out_valid_d = 1'b0;
                    end
                end
            end
            DONE: begin
                out_valid_d = 1'b0;
                if (!fetch_en) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        mem_end_d = (state_d == DONE);
    end

`ifdef FETCH_COUNT_EN
    always_comb begin
        fetch_count_d = fetch_count_q;
        if ((state_q == IDLE) && (state_d == RUN)) begin
            fetch_count_d = '0;
        end else if (out_valid_q && out_ready && (fetch_count_q != '1)) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end
`endif

    // NOTE: state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rp_q          <= '0;
            prog_len_q    <= '0;
            out_valid_q   <= 1'b0;
            instruction_q <= '0;
            address_q     <= '0;
            mem_end_q     <= 1'b0;
`ifdef FETCH_COUNT_EN
            fetch_count_q <= '0;
`endif
        end else begin
            state_q       <= state_d;
            rp_q          <= rp_d;
            prog_len_q    <= prog_len_d;
            out_valid_q   <= out_valid_d;
            instruction_q <= instruction_d;
            address_q     <= address_d;
            mem_end_q     <= mem_end_d;
`ifdef FETCH_COUNT_EN
            fetch_count_q <= fetch_count_d;
`endif
        end
    end

    assign out_valid   = out_valid_q;
    assign instruction = instruction_q;
    assign address     = address_q;
    assign mem_end     = mem_end_q;
`ifdef FETCH_COUNT_EN
    assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_mod_instruction_fetch_unit.sv
// Scoreboard bench for mod_instruction_fetch_unit: the driver pushes expected beats,
// a negedge monitor pops and compares every accepted beat and checks holds during stalls.
module tb_mod_instruction_fetch_unit;

    localparam int DW     = 32;
    localparam int AW     = 30;
    localparam int DEPTH  = 64;
    localparam int NWORDS = 34;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;
    logic          load_last;
    logic          fetch_en;
    logic          redirect_en;
    logic [AW-1:0] redirect_addr;
    logic          out_ready;
    logic          out_valid;
    logic [DW-1:0] instruction;
    logic [AW-1:0] address;
    logic          mem_end;
`ifdef FETCH_COUNT_EN
    logic [31:0]   fetch_count;
`endif

    mod_instruction_fetch_unit #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .load_en      (load_en),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .load_last    (load_last),
        .fetch_en     (fetch_en),
        .redirect_en  (redirect_en),
        .redirect_addr(redirect_addr),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .instruction  (instruction),
        .address      (address),
        .mem_end      (mem_end)
`ifdef FETCH_COUNT_EN
        ,
        .fetch_count  (fetch_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } beat_t;

    beat_t exp_q[$];
    int    tests = 0;
    int    fails = 0;
    int    first_cyc;
    int    last_cyc;
    int    stall_cnt;
    bit    first_pending;

    function automatic logic [DW-1:0] word_of(input int i);
        return 32'h0400_0001 + 32'(i) * 32'h0000_0100;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            exp_q.push_back('{addr: AW'(i), data: word_of(i)});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_addr(input int a, input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            step();
            if (out_valid === 1'b1 && address === AW'(a)) hit = 1'b1;
        end
        check(name, 64'(hit), 64'd1);
    endtask

    task automatic wait_mem_end(input string name, output int c);
        bit hit;
        hit = 1'b0;
        c   = -1;
        for (int i = 0; i < 200 && !hit; i++) begin
            step();
            if (mem_end === 1'b1) begin
                hit = 1'b1;
                c   = cyc;
            end
        end
        check(name, 64'(hit), 64'd1);
    endtask

    // Monitor: every accepted beat must match the queue head; a stalled beat must not move.
    initial begin
        logic          prev_stall;
        logic [AW-1:0] held_addr;
        logic [DW-1:0] held_data;
        beat_t         e;
        prev_stall = 1'b0;
        held_addr  = '0;
        held_data  = '0;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (prev_stall) begin
                    check("hold_addr", 64'(address), 64'(held_addr));
                    check("hold_instr", 64'(instruction), 64'(held_data));
                end
                if (out_ready === 1'b1) begin
                    prev_stall = 1'b0;
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_beat: got addr 0x%0h, expected no beat (cycle %0d)",
                                 address, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_addr", 64'(address), 64'(e.addr));
                        check("beat_instr", 64'(instruction), 64'(e.data));
                        if (first_pending) begin
                            first_cyc     = cyc;
                            first_pending = 1'b0;
                        end
                        last_cyc = cyc;
                    end
                end else begin
                    prev_stall = 1'b1;
                    held_addr  = address;
                    held_data  = instruction;
                    stall_cnt++;
                end
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int start;
        int end_cyc;

        rst           = 1'b1;
        load_en       = 1'b0;
        load_addr     = '0;
        load_data     = '0;
        load_last     = 1'b0;
        fetch_en      = 1'b0;
        redirect_en   = 1'b0;
        redirect_addr = '0;
        out_ready     = 1'b0;
        first_pending = 1'b0;
        first_cyc     = 0;
        last_cyc      = 0;
        stall_cnt     = 0;

        step();
        step();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_instr", 64'(instruction), 64'd0);
        check("rst_addr", 64'(address), 64'd0);
        check("rst_mem_end", 64'(mem_end), 64'd0);
        rst = 1'b0;

        // Fetch with an empty program must stay idle.
        fetch_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("empty_valid", 64'(out_valid), 64'd0);
            check("empty_mem_end", 64'(mem_end), 64'd0);
        end
        fetch_en = 1'b0;
        step();

        // Program load; the address-70 beat is out of range and must not alias onto word 6.
        for (int i = 0; i < NWORDS; i++) begin
            if (i == 20) begin
                load_en   = 1'b1;
                load_addr = AW'(70);
                load_data = 32'hDEAD_BEEF;
                load_last = 1'b0;
                step();
            end
            load_en   = 1'b1;
            load_addr = AW'(i);
            load_data = word_of(i);
            load_last = (i == NWORDS - 1);
            step();
        end
        load_en   = 1'b0;
        load_last = 1'b0;

        // Run A: full stream with a 3-cycle stall on address 5.
        push_range(0, NWORDS - 1);
        first_pending = 1'b1;
        stall_cnt     = 0;
        out_ready     = 1'b1;
        fetch_en      = 1'b1;
        start         = cyc;
        wait_addr(5, "a_reach_5");
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_mem_end("a_mem_end", end_cyc);
        check("a_first_latency", 64'(first_cyc), 64'(start + 2));
        check("a_last_cycle", 64'(last_cyc), 64'(first_cyc + NWORDS - 1 + 3));
        check("a_mem_end_cycle", 64'(end_cyc), 64'(last_cyc + 1));
        check("a_stall_cycles", 64'(stall_cnt), 64'd3);
        check("a_done_valid", 64'(out_valid), 64'd0);
`ifdef FETCH_COUNT_EN
        check("a_fetch_count", 64'(fetch_count), 64'(NWORDS));
`endif
        fetch_en = 1'b0;
        step();
        check("a_back_idle", 64'(mem_end), 64'd0);

        // Run B: redirect to 2 while address 10 is presented.
        push_range(0, 9);
        fetch_en = 1'b1;
        wait_addr(10, "b_reach_10");
        out_ready     = 1'b0;
        redirect_en   = 1'b1;
        redirect_addr = AW'(2);
        step();
        redirect_en = 1'b0;
        out_ready   = 1'b1;
        check("b_redir_bubble", 64'(out_valid), 64'd0);
        push_range(2, NWORDS - 1);
        step();
        check("b_resume_valid", 64'(out_valid), 64'd1);
        check("b_resume_addr", 64'(address), 64'd2);
        wait_mem_end("b_mem_end", end_cyc);
        fetch_en = 1'b0;
        step();

        // Run C: redirect past the program end.
        push_range(0, 2);
        fetch_en = 1'b1;
        wait_addr(3, "c_reach_3");
        out_ready     = 1'b0;
        redirect_en   = 1'b1;
        redirect_addr = AW'(40);
        step();
        redirect_en = 1'b0;
        out_ready   = 1'b1;
        check("c_redir_bubble", 64'(out_valid), 64'd0);
        step();
        check("c_oob_mem_end", 64'(mem_end), 64'd1);
        check("c_oob_valid", 64'(out_valid), 64'd0);
        fetch_en = 1'b0;
        step();
        check("c_back_idle", 64'(mem_end), 64'd0);

        // Run D: reset mid-run, then reload only the last word together with fetch_en.
        push_range(0, 6);
        fetch_en = 1'b1;
        wait_addr(7, "d_reach_7");
        rst       = 1'b1;
        out_ready = 1'b0;
        fetch_en  = 1'b0;
        step();
        rst = 1'b0;
        check("d_rst_valid", 64'(out_valid), 64'd0);
        check("d_rst_addr", 64'(address), 64'd0);
        check("d_rst_instr", 64'(instruction), 64'd0);
        check("d_rst_mem_end", 64'(mem_end), 64'd0);
        fetch_en = 1'b1;
        step();
        step();
        check("d_len_cleared", 64'(out_valid), 64'd0);
        push_range(0, NWORDS - 1);
        first_pending = 1'b1;
        out_ready     = 1'b1;
        load_en       = 1'b1;
        load_addr     = AW'(NWORDS - 1);
        load_data     = word_of(NWORDS - 1);
        load_last     = 1'b1;
        start         = cyc;
        step();
        load_en   = 1'b0;
        load_last = 1'b0;
        wait_addr(20, "d_reach_20");
        fetch_en = 1'b0;
        step();
        check("d_pause_bubble", 64'(out_valid), 64'd0);
        step();
        check("d_pause_hold", 64'(out_valid), 64'd0);
        fetch_en = 1'b1;
        wait_mem_end("d_mem_end", end_cyc);
        check("d_first_latency", 64'(first_cyc), 64'(start + 2));
`ifdef FETCH_COUNT_EN
        check("d_fetch_count", 64'(fetch_count), 64'(NWORDS));
`endif
        fetch_en = 1'b0;
        step();
        step();

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
